// File: rtl/spi_slave.sv
// SPI slave: oversamples sclk/cs_n/mosi in clk, full-duplex MSB-first words, one-entry TX buffer.
// Latency: pin edge to registered effect 3 clk (rx_valid 3 clk after the last sample edge).
// Backpressure: tx_ready low while the TX buffer holds a word; rx side is a pulse with no stall.
//
// Ports
//   clk, rst_n          system clock, async active-low reset
//   sclk, cs_n, mosi    asynchronous SPI pins from the master
//   miso, miso_oe       serial data to the master and its output enable
//   tx_data/valid/ready valid/ready write port into the one-entry TX buffer
//   rx_data, rx_valid   last completed received word, 1-clk update pulse
//   tx_underrun         1-clk pulse: TX_IDLE loaded because the buffer was empty
//   frame_err           1-clk pulse: cs_n rose in the middle of a word
//   busy                slave currently selected (synchronized cs_n low)
module spi_slave #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    CPOL       = 0,
    parameter int                    CPHA       = 0,
    parameter logic [DATA_WIDTH-1:0] TX_IDLE    = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int              CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic            CPOL_B   = (CPOL != 0);
    localparam logic            CPHA_B   = (CPHA != 0);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronizers. sclk and cs_n carry a history flop for edge
    // detection; mosi is consumed straight from its second stage.
    // ------------------------------------------------------------------
    logic sclk_s1_q, sclk_s2_q, sclk_h_q;
    logic cs_s1_q,   cs_s2_q,   cs_h_q;
    logic mosi_s1_q, mosi_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_h_q  <= 1'b0;
            cs_s1_q   <= 1'b0;
            cs_s2_q   <= 1'b0;
            cs_h_q    <= 1'b0;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            sclk_s1_q <= sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_h_q  <= sclk_s2_q;
            cs_s1_q   <= cs_n;
            cs_s2_q   <= cs_s1_q;
            cs_h_q    <= cs_s2_q;
            mosi_s1_q <= mosi;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    logic sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
    logic cs_fall, cs_rise;

    always_comb begin
        sclk_edge   = sclk_s2_q != sclk_h_q;
        // Leading edge leaves the idle level, trailing edge returns to it.
        lead_edge   = sclk_edge && (sclk_s2_q != CPOL_B);
        trail_edge  = sclk_edge && (sclk_s2_q == CPOL_B);
        sample_edge = CPHA_B ? trail_edge : lead_edge;
        shift_edge  = CPHA_B ? lead_edge  : trail_edge;
        cs_fall     = cs_h_q && !cs_s2_q;
        cs_rise     = !cs_h_q && cs_s2_q;
    end

    // ------------------------------------------------------------------
    // Control / datapath state
    // ------------------------------------------------------------------
    state_t                state_q,        state_d;
    logic [CNT_W-1:0]      bit_cnt_q,      bit_cnt_d;
    logic [DATA_WIDTH-1:0] rx_shift_q,     rx_shift_d;
    logic [DATA_WIDTH-1:0] tx_shift_q,     tx_shift_d;
    logic                  load_pending_q, load_pending_d;
    logic [DATA_WIDTH-1:0] buf_q,          buf_d;
    logic                  buf_full_q,     buf_full_d;
    logic [DATA_WIDTH-1:0] rx_data_q,      rx_data_d;
    logic                  rx_valid_q,     rx_valid_d;
    logic                  underrun_q,     underrun_d;
    logic                  frame_err_q,    frame_err_d;
    logic                  oe_q,           oe_d;

    logic                  do_load;
    logic [DATA_WIDTH-1:0] rx_word;

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        rx_shift_d     = rx_shift_q;
        tx_shift_d     = tx_shift_q;
        load_pending_d = load_pending_q;
        buf_d          = buf_q;
        buf_full_d     = buf_full_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        underrun_d     = 1'b0;
        frame_err_d    = 1'b0;
        oe_d           = oe_q;
        do_load        = 1'b0;
        rx_word        = {rx_shift_q[DATA_WIDTH-2:0], mosi_s2_q};

        unique case (state_q)
            IDLE: begin
                // sclk activity while deselected is ignored.
                if (cs_fall) begin
                    state_d    = ACTIVE;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    oe_d       = 1'b1;
                    if (CPHA_B) begin
                        // First bit is driven on the first leading edge.
                        load_pending_d = 1'b1;
                    end else begin
                        // First bit must be on miso before the first sample edge.
                        do_load        = 1'b1;
                        load_pending_d = 1'b0;
                    end
                end
            end
            ACTIVE: begin
                if (shift_edge) begin
                    if (load_pending_q) begin
                        do_load        = 1'b1;
                        load_pending_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
                if (sample_edge) begin
                    rx_shift_d = rx_word;
                    if (bit_cnt_q == CNT_LAST) begin
                        rx_data_d      = rx_word;
                        rx_valid_d     = 1'b1;
                        bit_cnt_d      = '0;
                        load_pending_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                // Deselect is judged on the count after any sample in this cycle.
                if (cs_rise) begin
                    state_d        = IDLE;
                    oe_d           = 1'b0;
                    load_pending_d = 1'b0;
                    if (bit_cnt_d != '0) begin
                        frame_err_d = 1'b1;
                    end
                    bit_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_load) begin
            if (buf_full_q) begin
                tx_shift_d = buf_q;
                buf_full_d = 1'b0;
            end else begin
                tx_shift_d = TX_IDLE;
                underrun_d = 1'b1;
            end
        end

        // Capture is evaluated on the pre-load occupancy, so a write landing
        // in the same cycle as a load from an empty buffer becomes the next word.
        if (tx_valid && !buf_full_q) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            rx_shift_q     <= '0;
            tx_shift_q     <= '0;
            load_pending_q <= 1'b0;
            buf_q          <= '0;
            buf_full_q     <= 1'b0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            underrun_q     <= 1'b0;
            frame_err_q    <= 1'b0;
            oe_q           <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            rx_shift_q     <= rx_shift_d;
            tx_shift_q     <= tx_shift_d;
            load_pending_q <= load_pending_d;
            buf_q          <= buf_d;
            buf_full_q     <= buf_full_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            underrun_q     <= underrun_d;
            frame_err_q    <= frame_err_d;
            oe_q           <= oe_d;
        end
    end

    assign miso        = tx_shift_q[DATA_WIDTH-1];
    assign miso_oe     = oe_q;
    assign tx_ready    = !buf_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;
    assign frame_err   = frame_err_q;
    assign busy        = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
// Testbench for spi_slave: all four SPI modes instantiated side by side and driven by one master.
// Expected words come from protocol-level queues (words offered, words captured, words sent).
// A monitor pops expected rx words on every rx_valid and counts underrun/frame_err pulses.
module tb_spi_slave;

    localparam int          DW  = 8;
    localparam int          NM  = 4;
    localparam logic [DW-1:0] TXI = 8'h00;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cs_n_t;
    logic [NM-1:0] sclk_a, mosi_a, miso_a, oe_a, txv_a, txr_a, rxv_a, urun_a, ferr_a, busy_a;
    logic [DW-1:0] txd_a [NM];
    logic [DW-1:0] rxd_a [NM];

    always #5 clk = ~clk;

    // Mode m: CPOL = m[1], CPHA = m[0].
    for (genvar g = 0; g < NM; g++) begin : g_dut
        spi_slave #(
            .DATA_WIDTH(DW),
            .CPOL      (g / 2),
            .CPHA      (g % 2),
            .TX_IDLE   (TXI)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .sclk       (sclk_a[g]),
            .cs_n       (cs_n_t),
            .mosi       (mosi_a[g]),
            .miso       (miso_a[g]),
            .miso_oe    (oe_a[g]),
            .tx_data    (txd_a[g]),
            .tx_valid   (txv_a[g]),
            .tx_ready   (txr_a[g]),
            .rx_data    (rxd_a[g]),
            .rx_valid   (rxv_a[g]),
            .tx_underrun(urun_a[g]),
            .frame_err  (ferr_a[g]),
            .busy       (busy_a[g])
        );
    end

    // Reference model state
    logic [DW-1:0] src_q  [NM][$];   // words the bench will offer on tx
    logic [DW-1:0] tx_q   [NM][$];   // words accepted by the slave, not yet loaded
    logic [DW-1:0] exp_rx [NM][$];   // words the slave must report on rx
    logic [DW-1:0] cur_tx [NM];      // word the slave should currently be sending
    logic [DW-1:0] last_rx[NM];
    logic [DW-1:0] mw     [NM][16];  // master outgoing words for the next frame
    int exp_urun[NM], cnt_urun[NM], exp_ferr[NM], cnt_ferr[NM];
    int checks = 0;
    int failures = 0;

    function automatic logic idle_lvl(input int m);
        return logic'((m / 2) % 2);
    endfunction

    task automatic chk(input string nm, input int m, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s mode=%0d got=%0h exp=%0h t=%0t", nm, m, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int m);
        if (tx_q[m].size() > 0) begin
            cur_tx[m] = tx_q[m].pop_front();
        end else begin
            cur_tx[m] = TXI;
            exp_urun[m]++;
        end
    endtask

    task automatic chk_reset_vals();
        for (int m = 0; m < NM; m++) begin
            chk("rst_miso",     m, 32'(miso_a[m]), 32'd0);
            chk("rst_miso_oe",  m, 32'(oe_a[m]),   32'd0);
            chk("rst_rx_valid", m, 32'(rxv_a[m]),  32'd0);
            chk("rst_underrun", m, 32'(urun_a[m]), 32'd0);
            chk("rst_frame_err",m, 32'(ferr_a[m]), 32'd0);
            chk("rst_busy",     m, 32'(busy_a[m]), 32'd0);
            chk("rst_tx_ready", m, 32'(txr_a[m]),  32'd1);
            chk("rst_rx_data",  m, 32'(rxd_a[m]),  32'd0);
        end
    endtask

    task automatic chk_counts(input string tag);
        for (int m = 0; m < NM; m++) begin
            chk({tag, "_underrun_cnt"}, m, 32'(cnt_urun[m]), 32'(exp_urun[m]));
            chk({tag, "_frame_err_cnt"}, m, 32'(cnt_ferr[m]), 32'(exp_ferr[m]));
            chk({tag, "_rx_missing"}, m, 32'(exp_rx[m].size()), 32'd0);
        end
    endtask

    // One cs_n-low frame on all four slaves: nw full words then part extra bits.
    // Each sclk phase lasts p clocks. rst_mid replaces the deselect with a reset.
    task automatic frame(input int nw, input int part, input int p, input bit rst_mid);
        int nbits;
        logic [DW-1:0] rx_as [NM];
        nbits = nw * DW + part;
        for (int m = 0; m < NM; m++) rx_as[m] = '0;
        cs_n_t = 1'b0;
        for (int m = 0; m < NM; m += 2) begin
            do_load(m);
            mosi_a[m] = mw[m][0][DW-1];
        end
        tick(p);
        for (int i = 0; i < nbits; i++) begin
            int  w;
            int  b;
            bit  last;
            w    = i / DW;
            b    = DW - 1 - (i % DW);
            last = (i % DW) == DW - 1;
            if (i == 0) begin
                for (int m = 0; m < NM; m++) begin
                    chk("sel_busy",    m, 32'(busy_a[m]), 32'd1);
                    chk("sel_miso_oe", m, 32'(oe_a[m]),   32'd1);
                end
            end
            // leading edge
            for (int m = 0; m < NM; m++) begin
                if (m % 2 == 0) begin
                    rx_as[m] = {rx_as[m][DW-2:0], miso_a[m]};
                end else begin
                    if (i % DW == 0) do_load(m);
                    mosi_a[m] = mw[m][w][b];
                end
                sclk_a[m] = ~idle_lvl(m);
                if (m % 2 == 0 && last) begin
                    exp_rx[m].push_back(mw[m][w]);
                    last_rx[m] = mw[m][w];
                    chk("miso_word", m, 32'(rx_as[m]), 32'(cur_tx[m]));
                end
            end
            tick(p);
            // trailing edge
            for (int m = 0; m < NM; m++) begin
                if (m % 2 == 1) rx_as[m] = {rx_as[m][DW-2:0], miso_a[m]};
                sclk_a[m] = idle_lvl(m);
                if (m % 2 == 1 && last) begin
                    exp_rx[m].push_back(mw[m][w]);
                    last_rx[m] = mw[m][w];
                    chk("miso_word", m, 32'(rx_as[m]), 32'(cur_tx[m]));
                end
                if (m % 2 == 0) begin
                    // CPHA=0 reloads on the trailing edge after every completed
                    // word, including the last one; that word is never sent.
                    if (last) do_load(m);
                    if (i + 1 < nbits) mosi_a[m] = mw[m][(i + 1) / DW][DW - 1 - ((i + 1) % DW)];
                end
            end
            tick(p);
        end
        if (rst_mid) begin
            rst_n = 1'b0;
            tick(2);
            chk_reset_vals();
            cs_n_t = 1'b1;
            for (int m = 0; m < NM; m++) begin
                sclk_a[m] = idle_lvl(m);
                mosi_a[m] = 1'b0;
                tx_q[m].delete();
                last_rx[m] = '0;
            end
            tick(4);
            rst_n = 1'b1;
        end else begin
            cs_n_t = 1'b1;
            if (part > 0) begin
                for (int m = 0; m < NM; m++) exp_ferr[m]++;
            end
        end
        tick(p + 6);
        for (int m = 0; m < NM; m++) begin
            chk("desel_busy",    m, 32'(busy_a[m]), 32'd0);
            chk("desel_miso_oe", m, 32'(oe_a[m]),   32'd0);
        end
    endtask

    // TX feeder: offers src_q words; an accepted word moves to tx_q.
    initial begin : feeder
        logic [NM-1:0] hs;
        logic [DW-1:0] junk;
        txv_a = '0;
        for (int m = 0; m < NM; m++) txd_a[m] = '0;
        forever begin
            @(negedge clk);
            hs = rst_n ? (txv_a & txr_a) : '0;
            @(posedge clk);
            #1;
            for (int m = 0; m < NM; m++) begin
                if (hs[m]) begin
                    tx_q[m].push_back(txd_a[m]);
                    junk = src_q[m].pop_front();
                end
                if (src_q[m].size() > 0) begin
                    txv_a[m] = 1'b1;
                    txd_a[m] = src_q[m][0];
                end else begin
                    txv_a[m] = 1'b0;
                end
            end
        end
    end

    // Monitor: every rx_valid must match the oldest expected word.
    initial begin : monitor
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            for (int m = 0; m < NM; m++) begin
                if (rxv_a[m]) begin
                    if (exp_rx[m].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rx_unexpected mode=%0d got=%0h exp=none t=%0t", m, rxd_a[m], $time);
                    end else begin
                        e = exp_rx[m].pop_front();
                        chk("rx_data", m, 32'(rxd_a[m]), 32'(e));
                    end
                end
                if (urun_a[m]) cnt_urun[m]++;
                if (ferr_a[m]) cnt_ferr[m]++;
            end
        end
    end

    initial begin : main
        int total;
        int nw;
        cs_n_t = 1'b1;
        for (int m = 0; m < NM; m++) begin
            sclk_a[m]   = idle_lvl(m);
            mosi_a[m]   = 1'b0;
            cur_tx[m]   = '0;
            last_rx[m]  = '0;
            exp_urun[m] = 0;
            cnt_urun[m] = 0;
            exp_ferr[m] = 0;
            cnt_ferr[m] = 0;
        end
        rst_n = 1'b0;
        tick(5);
        chk_reset_vals();
        rst_n = 1'b1;
        tick(6);

        // T1: preloaded A5 out, 3C in, every mode
        for (int m = 0; m < NM; m++) begin
            src_q[m].push_back(8'hA5);
            mw[m][0] = 8'h3C;
        end
        tick(4);
        frame(1, 0, 6, 1'b0);
        for (int m = 0; m < NM; m++) chk("t1_rx_data", m, 32'(rxd_a[m]), 32'h3C);
        chk_counts("t1");

        // T4: abort after 5 sample edges; rx_data must hold 3C
        for (int m = 0; m < NM; m++) mw[m][0] = DW'($urandom);
        frame(0, 5, 6, 1'b0);
        for (int m = 0; m < NM; m++) chk("t4_rx_hold", m, 32'(rxd_a[m]), 32'h3C);
        chk_counts("t4");
        for (int m = 0; m < NM; m++) mw[m][0] = 8'h96;
        frame(1, 0, 6, 1'b0);
        for (int m = 0; m < NM; m++) chk("t4_next_rx", m, 32'(rxd_a[m]), 32'h96);
        chk_counts("t4b");

        // T2: back-to-back 11/22 out, F0/0F in
        for (int m = 0; m < NM; m++) begin
            src_q[m].push_back(8'h11);
            src_q[m].push_back(8'h22);
            mw[m][0] = 8'hF0;
            mw[m][1] = 8'h0F;
        end
        tick(6);
        frame(2, 0, 6, 1'b0);
        for (int m = 0; m < NM; m++) chk("t2_rx_data", m, 32'(rxd_a[m]), 32'h0F);
        chk_counts("t2");

        // T3: empty buffer, master reads TX_IDLE; CPHA=0 modes also underrun
        // on the reload after the last word, so they pulse twice.
        for (int m = 0; m < NM; m++) mw[m][0] = 8'h5A;
        frame(1, 0, 6, 1'b0);
        for (int m = 0; m < NM; m++) chk("t3_rx_data", m, 32'(rxd_a[m]), 32'h5A);
        chk_counts("t3");

        // T5: reset after 3 bits, then a clean C3 frame
        for (int m = 0; m < NM; m++) mw[m][0] = DW'($urandom);
        frame(0, 3, 6, 1'b1);
        for (int m = 0; m < NM; m++) mw[m][0] = 8'hC3;
        frame(1, 0, 6, 1'b0);
        for (int m = 0; m < NM; m++) chk("t5_rx_data", m, 32'(rxd_a[m]), 32'hC3);
        chk_counts("t5");

        // T6: random data at the minimum sclk phase of 4 clk
        for (int m = 0; m < NM; m++) begin
            for (int k = 0; k < 400; k++) src_q[m].push_back(DW'($urandom));
        end
        tick(6);
        total = 0;
        while (total < 256) begin
            nw = int'($urandom_range(1, 8));
            for (int m = 0; m < NM; m++) begin
                for (int k = 0; k < nw; k++) mw[m][k] = DW'($urandom);
            end
            frame(nw, 0, 4, 1'b0);
            total += nw;
        end
        for (int m = 0; m < NM; m++) chk("t6_rx_last", m, 32'(rxd_a[m]), 32'(last_rx[m]));
        chk_counts("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
